cic_interp_iq: RTL and testbench

- Parametrised I/Q CIC interpolator that succeeds the fixed 8x, two-clock-domain upsampler.
- Runs entirely on the system clock. The low-rate input and high-rate output are paced by internal clock-enable ticks, not by derived clocks.
- Supports runtime baud selection, a configurable CIC order and interpolation factor, and an input valid/ready handshake with underrun reporting.
- Sits between the pulse-shaping FIR outputs and the NCO mixer.

---
 rtl/cic_interp_iq.sv | 99 +++++++++
 tb/tb_cic_interp_iq.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/cic_interp_iq.sv
// cic_interp_iq: I/Q CIC interpolator on one system clock, with ticks from a clock-enable divider
module cic_interp_iq #(
  parameter int IN_W = 32,
  parameter int N_STAGES = 3,
  parameter int R_LOG2 = 3,
  parameter int BASE_DIV = 18,
  localparam int OUT_W = IN_W + (N_STAGES - 1) * R_LOG2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [1:0]              baud_rate,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_i,
  input  logic signed [IN_W-1:0]  in_q,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] out_i,
  output logic signed [OUT_W-1:0] out_q,
  output logic                    underrun,
  input  logic                    clr_underrun
);
  localparam int DW = $clog2(BASE_DIV * 8 + 1);
  logic [DW-1:0] div_q, div_d, cnt_q, cnt_d;
  logic [R_LOG2-1:0] ph_q, ph_d;
  logic first_q, first_d, full_q, full_d, vld_q, vld_d, unr_q, unr_d;
  logic tick, ph0, take;
  logic signed [IN_W-1:0] buf_q [2];
  logic signed [IN_W-1:0] buf_d [2];
  logic signed [OUT_W-1:0] dly_q [2][N_STAGES];
  logic signed [OUT_W-1:0] dly_d [2][N_STAGES];
  logic signed [OUT_W-1:0] integ_q [2][N_STAGES];
  logic signed [OUT_W-1:0] integ_d [2][N_STAGES];
  logic signed [OUT_W-1:0] y_q [2];
  logic signed [OUT_W-1:0] y_d [2];
  logic signed [OUT_W-1:0] cv, acc;
  // Tick pacing, divisor latch, buffer handshake and the comb/integrator chains per channel
  always_comb begin
    tick = en && (cnt_q == div_q - 1'b1);
    ph0 = tick && (ph_q == '0);
    take = in_valid && !full_q;
    cnt_d = !en ? cnt_q : (tick || first_q) ? '0 : cnt_q + 1'b1;
    div_d = (en && (tick || first_q)) ? DW'(BASE_DIV << (2'd3 - baud_rate)) : div_q;
    first_d = first_q && !en;
    ph_d = tick ? ph_q + 1'b1 : ph_q;
    full_d = take || (full_q && !ph0);
    unr_d = (ph0 && !full_q) || (unr_q && !clr_underrun);
    vld_d = tick;
    cv = '0;
    acc = '0;
    for (int c = 0; c < 2; c++) begin
      buf_d[c] = take ? ((c == 1) ? in_q : in_i) : buf_q[c];
      cv = full_q ? OUT_W'(buf_q[c]) : '0;
      for (int k = 0; k < N_STAGES; k++) begin
        dly_d[c][k] = ph0 ? cv : dly_q[c][k];
        cv = cv - dly_q[c][k];
      end
      acc = ph0 ? cv : '0;
      for (int k = 0; k < N_STAGES; k++) begin
        acc = integ_q[c][k] + acc;
        integ_d[c][k] = tick ? acc : integ_q[c][k];
      end
      y_d[c] = tick ? acc : y_q[c];
    end
  end
  // State registers with synchronous active-low reset; the divisor reloads the slowest setting
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q <= DW'(BASE_DIV * 8);
      cnt_q <= '0;
      ph_q <= '0;
      first_q <= 1'b1;
      full_q <= 1'b0;
      vld_q <= 1'b0;
      unr_q <= 1'b0;
      buf_q <= '{default: '0};
      dly_q <= '{default: '{default: '0}};
      integ_q <= '{default: '{default: '0}};
      y_q <= '{default: '0};
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
      ph_q <= ph_d;
      first_q <= first_d;
      full_q <= full_d;
      vld_q <= vld_d;
      unr_q <= unr_d;
      buf_q <= buf_d;
      dly_q <= dly_d;
      integ_q <= integ_d;
      y_q <= y_d;
    end
  end
  assign in_ready = !full_q;
  assign out_valid = vld_q;
  assign out_i = y_q[0];
  assign out_q = y_q[1];
  assign underrun = unr_q;
endmodule

// File: tb/tb_cic_interp_iq.sv
// tb_cic_interp_iq: directed checks of the I/Q CIC interpolator
module tb_cic_interp_iq;
  localparam int IN_W = 32;
  localparam int OUT_W = 38;
  logic clk = 0;
  logic rst_n, en, in_valid, in_ready, out_valid, underrun, clr_underrun;
  logic [1:0] baud_rate;
  logic signed [IN_W-1:0] in_i, in_q;
  logic signed [OUT_W-1:0] out_i, out_q;
  int errors = 0;
  int checks = 0;

  cic_interp_iq dut (
    .clk(clk), .rst_n(rst_n), .en(en), .baud_rate(baud_rate),
    .in_valid(in_valid), .in_ready(in_ready), .in_i(in_i), .in_q(in_q),
    .out_valid(out_valid), .out_i(out_i), .out_q(out_q),
    .underrun(underrun), .clr_underrun(clr_underrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 400);
    if (!out_valid) check("tick_timeout", 64'(out_valid), 1);
  endtask

  task automatic impulse();
    logic signed [63:0] h [30];
    int n;
    in_i = 1;
    in_q = 0;
    in_valid = 1;
    @(negedge clk);
    in_i = 0;
    for (int i = 0; i < 30; i++) begin
      wait_tick(n);
      h[i] = out_i;
      if (i == 3) check("imp_q", out_q, 0);
    end
    check("imp_h0", h[0], 1);
    check("imp_h1", h[1], 3);
    check("imp_h2", h[2], 6);
    check("imp_h3", h[3], 10);
    check("imp_h4", h[4], 15);
    for (int i = 24; i < 30; i++) check("imp_tail", h[i], 0);
  endtask

  initial begin
    int n, k, cnt;
    rst_n = 0; en = 1; baud_rate = 2'b11; in_valid = 0; in_i = 0; in_q = 0; clr_underrun = 0;
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(in_ready), 1);
    check("rst_valid", 64'(out_valid), 0);
    check("rst_out_i", out_i, 0);
    check("rst_out_q", out_q, 0);
    check("rst_underrun", 64'(underrun), 0);
    rst_n = 1;
    impulse();
    wait_tick(n);
    wait_tick(n);
    check("period_11", n, 18);
    cnt = 0;
    repeat (288) begin
      @(negedge clk);
      if (in_valid && in_ready) cnt++;
    end
    check("xfers_16_ticks", cnt, 2);
    in_i = 1000;
    in_q = -1000;
    repeat (40) wait_tick(n);
    check("dc_i", out_i, 64000);
    check("dc_q", out_q, -64000);
    wait_tick(n);
    check("dc_i_next", out_i, 64000);
    in_i = 32'sh80000000;
    in_q = 32'sh7fffffff;
    repeat (40) wait_tick(n);
    check("dc_min_i", out_i, -(64'sd1 <<< 37));
    check("dc_max_q", out_q, (64'sd1 <<< 37) - 64);
    check("no_underrun", 64'(underrun), 0);
    in_valid = 0;
    k = 0;
    do begin
      wait_tick(n);
      k++;
    end while (!underrun && k < 10);
    check("underrun_set", 64'(underrun), 1);
    repeat (40) wait_tick(n);
    check("zero_inject_i", out_i, 0);
    check("zero_inject_q", out_q, 0);
    clr_underrun = 1;
    @(negedge clk);
    clr_underrun = 0;
    check("underrun_clr", 64'(underrun), 0);
    repeat (7) wait_tick(n);
    check("underrun_held_clr", 64'(underrun), 0);
    clr_underrun = 1;
    wait_tick(n);
    clr_underrun = 0;
    check("underrun_set_wins", 64'(underrun), 1);
    in_valid = 1; in_i = 0; in_q = 0;
    clr_underrun = 1;
    @(negedge clk);
    clr_underrun = 0;
    wait_tick(n);
    repeat (5) @(negedge clk);
    baud_rate = 2'b10;
    wait_tick(n);
    check("baud_cur_period", n + 5, 18);
    wait_tick(n);
    check("baud_new_period", n, 36);
    baud_rate = 2'b00;
    wait_tick(n);
    check("baud00_first", n, 36);
    wait_tick(n);
    check("period_00", n, 144);
    en = 0;
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("en0_no_ticks", cnt, 0);
    en = 1;
    wait_tick(n);
    check("en0_frozen_cnt", n, 144);
    baud_rate = 2'b11;
    in_i = 5;
    in_q = 7;
    repeat (12) wait_tick(n);
    @(negedge clk);
    check("pre_rst_full", 64'(in_ready), 0);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    check("mid_rst_out_i", out_i, 0);
    check("mid_rst_out_q", out_q, 0);
    check("mid_rst_ready", 64'(in_ready), 1);
    check("mid_rst_underrun", 64'(underrun), 0);
    impulse();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
